// File: rtl/adder_2_serial_seq_if.sv
// Request/response bus for adder_2_serial_seq: start/operands in, busy/done/result out.
interface adder_2_serial_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             Cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout_out;
  logic             err;

  modport master (
    output start, A_in, B_in, Cin_in,
    input  busy, done, Sum, Cout_out, err
  );

  modport slave (
    input  start, A_in, B_in, Cin_in,
    output busy, done, Sum, Cout_out, err
  );
endinterface

// File: rtl/adder_2_serial_seq.sv
// Digit-serial sequencer feeding a combinational 2-bit adder stage, LSB slice first.
// Optional ADDER_XCHECK_EN compares the adder's core outputs against its ripple outputs.
module adder_2_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  adder_2_serial_seq_if.slave    bus,
  output logic                   A0,
  output logic                   A1,
  output logic                   B0,
  output logic                   B1,
  output logic                   Cin,
  input  logic                   S0,
  input  logic                   S1,
  input  logic                   Cout,
  input  logic [1:0]             Core_Sum,
  input  logic                   Core_Cout
);
  localparam int NS = WIDTH / 2;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_r_sh;
  logic             r_cr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_run, w_last;
  logic [WIDTH-1:0] w_sh_next;

  // Result word with the current slice entering at the top.
  generate
    if (WIDTH == 2) begin : g_w2
      assign w_sh_next = {S1, S0};
    end else begin : g_wn
      assign w_sh_next = {S1, S0, r_r_sh[WIDTH-1:2]};
    end
  endgenerate

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == CW'(NS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    A0  = 1'b0;
    A1  = 1'b0;
    B0  = 1'b0;
    B1  = 1'b0;
    Cin = 1'b0;
    if (w_run) begin
      A0  = r_a_sh[0];
      A1  = r_a_sh[1];
      B0  = r_b_sh[0];
      B1  = r_b_sh[1];
      Cin = r_cr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_r_sh  <= '0;
      r_cr    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a_sh <= bus.A_in;
          r_b_sh <= bus.B_in;
          r_cr   <= bus.Cin_in;
          r_cnt  <= '0;
        end
        S_RUN: begin
          r_a_sh <= r_a_sh >> 2;
          r_b_sh <= r_b_sh >> 2;
          r_r_sh <= w_sh_next;
          r_cr   <= Cout;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_sh_next;
            r_cout <= Cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_XCHECK_EN
  logic r_err;

  // Sticky until reset or the next accepted start; never touches the result path.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_err <= 1'b0;
    end else if (w_run && ({Core_Cout, Core_Sum} != {Cout, S1, S0})) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_core;
  assign w_unused_core = ^{Core_Sum, Core_Cout};
  assign bus.err       = 1'b0;
`endif

  assign bus.busy     = w_run;
  assign bus.done     = (r_state == S_DONE);
  assign bus.Sum      = r_sum;
  assign bus.Cout_out = r_cout;
endmodule
